// File: rtl/iob_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// iob_mem_responder_pkg : shared bus-field layout and wait-state constants
// Revision: 1.0
// ============================================================================
package iob_mem_responder_pkg;

  // Fibonacci LFSR taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int RESP_READY_BIT  = 0;
  localparam int RESP_RVALID_BIT = 1;
  localparam int RESP_RDATA_LSB  = 2;

  typedef enum logic [0:0] {
    XFER_READ  = 1'b0,
    XFER_WRITE = 1'b1
  } xfer_e;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_mem_responder_wait.sv
`default_nettype none
// ============================================================================
// iob_mem_responder_wait : LFSR-driven ready register producing ~25% wait states
// Revision: 1.0
// ============================================================================
module iob_mem_responder_wait
  import iob_mem_responder_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cke,
  output logic ready
);

  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = {lfsr[14:0], ^(lfsr & LFSR_TAPS)};

  // ready follows the value the LFSR is stepping into, so both move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr  <= SEED;
      ready <= 1'b0;
    end else if (cke) begin
      lfsr  <= lfsr_nxt;
      ready <= (lfsr_nxt[1:0] != 2'b00);
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_mem_responder.sv
`default_nettype none
// ============================================================================
// iob_mem_responder : IOb subordinate with internal byte-enabled RAM, fixed read
// latency. Optional wait states with `define IOB_MEM_RESPONDER_WAIT_EN.
// Revision: 1.0
// ============================================================================
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_ADDR_W = 10,
  parameter int READ_LAT   = 1
`ifdef IOB_MEM_RESPONDER_WAIT_EN
  ,
  parameter logic [15:0] WAIT_SEED = 16'hACE1
`endif
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic                           cke_i,
  input  logic [req_w(ADDR_W, DATA_W)-1:0] req_i,
  output logic [resp_w(DATA_W)-1:0]      resp_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int DEPTH  = 1 << MEM_ADDR_W;

  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  ready;
  logic                  accept;
  logic                  rd_accept;
  xfer_e                 kind;
  logic [MEM_ADDR_W-1:0] word_idx;
  logic                  unused_addr;

  assign {valid, addr, wdata, wstrb} = req_i;

  // upper bits alias and the byte offset is irrelevant for word access
  assign word_idx    = addr[MEM_ADDR_W+1:2];
  assign unused_addr = ^addr;

  assign kind      = (wstrb != '0) ? XFER_WRITE : XFER_READ;
  assign accept    = valid & ready & cke_i;
  assign rd_accept = accept & (kind == XFER_READ);

`ifdef IOB_MEM_RESPONDER_WAIT_EN
  iob_mem_responder_wait #(
    .SEED (WAIT_SEED)
  ) u_wait (
    .clk   (clk_i),
    .rst_n (arst_n_i),
    .cke   (cke_i),
    .ready (ready)
  );
`else
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      ready <= 1'b0;
    end else if (cke_i) begin
      ready <= 1'b1;
    end
  end
`endif

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (accept && kind == XFER_WRITE) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Each data stage only loads behind a valid token, so the last stage
  // doubles as the held rdata register between pulses.
  logic [READ_LAT-1:0] pipe_v;
  logic [DATA_W-1:0]   pipe_d [READ_LAT];

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_d[i] <= '0;
    end else if (cke_i) begin
      pipe_v[0] <= rd_accept;
      if (rd_accept) pipe_d[0] <= mem[word_idx];
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign resp_o = {pipe_d[READ_LAT-1], pipe_v[READ_LAT-1], ready};

endmodule
`default_nettype wire

// File: tb/tb_iob_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_iob_mem_responder : directed + random checks against a word-array model
// Revision: 1.0
// ============================================================================
module tb_iob_mem_responder;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_ADDR_W = 10;
  localparam int READ_LAT   = 3;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cke = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [68:0] req;
  logic [33:0] resp;
  logic        ready, rvalid;
  logic [31:0] rdata;

  assign req    = {valid, addr, wdata, wstrb};
  assign ready  = resp[0];
  assign rvalid = resp[1];
  assign rdata  = resp[33:2];

  always #5 clk = ~clk;

  iob_mem_responder #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_ADDR_W (MEM_ADDR_W),
    .READ_LAT   (READ_LAT)
  ) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .cke_i    (cke),
    .req_i    (req),
    .resp_o   (resp)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mdl [1024];
  rd_t         pend [$];
  int          tick;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  logic        exp_ready;
  logic        last_acc;
  int          passed = 0;
  int          total = 0;
  int          ready_hi = 0;
  int          ready_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    pend.delete();
    exp_rvalid = 1'b0;
    exp_rdata  = '0;
    exp_ready  = 1'b0;
  endtask

  // One clock: drive, sample at negedge, then advance the model at the edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic ck);
    logic [9:0] w;
    valid = v; addr = a; wdata = d; wstrb = s; cke = ck;
    @(negedge clk);
`ifndef IOB_MEM_RESPONDER_WAIT_EN
    check("ready", 32'(ready), 32'(exp_ready));
`endif
    check("rvalid", 32'(rvalid), 32'(exp_rvalid));
    check("rdata", rdata, exp_rdata);
    if (arst_n && ck) begin
      ready_cnt++;
      if (ready) ready_hi++;
    end
    last_acc = v & ready & ck & arst_n;
    w = a[11:2];
    @(posedge clk);
    if (arst_n && ck) begin
      if (last_acc && s != 4'h0) begin
        for (int b = 0; b < 4; b++) if (s[b]) mdl[w][8*b +: 8] = d[8*b +: 8];
      end else if (last_acc) begin
        pend.push_back('{due: tick + READ_LAT, data: mdl[w]});
      end
      tick++;
      exp_ready  = 1'b1;
      exp_rvalid = 1'b0;
      if (pend.size() > 0 && pend[0].due == tick) begin
        exp_rvalid = 1'b1;
        exp_rdata  = pend[0].data;
        void'(pend.pop_front());
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
  endtask

  // Holds the request until accepted; a stuck ready counts as a failure.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int tries = 0;
    do begin
      step(1'b1, a, d, s, 1'b1);
      tries++;
    end while (!last_acc && tries < 32);
    if (!last_acc) check("accept_timeout", 32'(tries), 32'(0));
  endtask

  task automatic pulse_reset();
    arst_n = 1'b0;
    #1;
    model_reset();
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    arst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    int          widx;
    tick = 0;
    model_reset();

    // reset state and ready rising after release
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    arst_n = 1'b1;
    idle(2);

    // full-word write then read
    xfer(32'h10, 32'hDEADBEEF, 4'hF);
    xfer(32'h10, 32'h0, 4'h0);
    idle(READ_LAT + 1);

    // byte write followed immediately by a read of the same word
    xfer(32'h10, 32'h00000055, 4'h1);
    xfer(32'h10, 32'h0, 4'h0);
    idle(READ_LAT + 1);

    // back-to-back reads fill the pipe
    for (int i = 0; i < 4; i++) xfer(32'(i * 4), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) xfer(32'(i * 4), 32'h0, 4'h0);
    idle(READ_LAT + 2);

    // reset while a read is in flight drops it; RAM survives
    xfer(32'h10, 32'h0, 4'h0);
    idle(1);
    pulse_reset();
    idle(READ_LAT + 2);
    xfer(32'h10, 32'h0, 4'h0);
    idle(READ_LAT + 1);

    // cke low: rvalid held, no write lands
    xfer(32'h20, 32'hCAFE0001, 4'hF);
    xfer(32'h20, 32'h0, 4'h0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    idle(2);
    xfer(32'h20, 32'h0, 4'h0);
    idle(READ_LAT + 1);

    // upper address bits alias onto the same word
    xfer(32'h0000_1010, 32'hA5A5_0000, 4'hC);
    xfer(32'h10, 32'h0, 4'h0);
    xfer(32'h8000_0013, 32'h0, 4'h0);
    idle(READ_LAT + 1);

    // random traffic over a prefilled window
    for (int i = 0; i < 16; i++) xfer(32'h100 + 32'(i * 4), $urandom, 4'hF);
    ready_hi = 0;
    ready_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      widx = int'($urandom_range(0, 15));
      a = ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(widx * 4)) | ($urandom & 32'h3);
      d = $urandom;
      s = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      step($urandom_range(0, 3) != 0, a, d, s, $urandom_range(0, 7) != 0);
    end
    idle(READ_LAT + 2);
`ifdef IOB_MEM_RESPONDER_WAIT_EN
    check("ready_duty_in_70_80",
          32'((ready_hi * 100 >= ready_cnt * 70) && (ready_hi * 100 <= ready_cnt * 80)), 32'(1));
`else
    check("ready_duty_full", 32'(ready_hi), 32'(ready_cnt));
`endif
    check("pending_drained", 32'(pend.size()), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
